// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded ID-side fields in, registered EX-side fields plus stall/counters out.
//   master : ID-side driver (drives id_*, control, flush; observes stall and ex_*)
//   slave  : the ID/EX register itself
interface id_ex_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
);
  localparam int unsigned REG_W   = 5;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned OP_W    = 2;

  // ID side
  logic               id_valid;
  logic               RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite;
  logic               Branch, Jump, ExtendSel;
  logic [OP_W-1:0]    ALUOp;
  logic [DATA_W-1:0]  id_rs_data, id_rt_data, id_pc4;
  logic [REG_W-1:0]   id_rs, id_rt, id_rd;
  logic [IMM_W-1:0]   id_imm;
  logic [FUNCT_W-1:0] id_funct;
  logic               flush;

  // EX side
  logic               stall;
  logic               ex_valid;
  logic               ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write;
  logic               ex_mem_read, ex_mem_write, ex_branch, ex_jump;
  logic [OP_W-1:0]    ex_alu_op;
  logic [DATA_W-1:0]  ex_rs_data, ex_rt_data, ex_imm_ext, ex_pc4;
  logic [REG_W-1:0]   ex_rs, ex_rt, ex_write_reg;
  logic [FUNCT_W-1:0] ex_funct;
  logic [CNT_W-1:0]   stall_cnt, flush_cnt;

  modport master (
    output id_valid, RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
           Branch, Jump, ExtendSel, ALUOp, id_rs_data, id_rt_data, id_pc4,
           id_rs, id_rt, id_rd, id_imm, id_funct, flush,
    input  stall, ex_valid, ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_alu_op,
           ex_rs_data, ex_rt_data, ex_imm_ext, ex_pc4, ex_rs, ex_rt,
           ex_write_reg, ex_funct, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
           Branch, Jump, ExtendSel, ALUOp, id_rs_data, id_rt_data, id_pc4,
           id_rs, id_rt, id_rd, id_imm, id_funct, flush,
    output stall, ex_valid, ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_alu_op,
           ex_rs_data, ex_rt_data, ex_imm_ext, ex_pc4, ex_rs, ex_rt,
           ex_write_reg, ex_funct, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
//   clk, rst : clock and synchronous active-high reset
//   bus      : id_ex_stage_if.slave -- decoded ID fields in; registered EX fields,
//              combinational stall, and saturating stall/flush event counters out
module id_ex_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic          clk,
  input  logic          rst,
  id_ex_stage_if.slave  bus
);
  localparam int unsigned IMM_W = 16;
  localparam int unsigned OP_W  = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic uses_rs, uses_rt, hazard, stall_c, bubble;
  logic [DATA_W-1:0] imm_ext;

  // Which source registers the ID instruction actually reads
  assign uses_rs = bus.id_valid & ~bus.Jump;
  assign uses_rt = bus.id_valid & (bus.RegDst | bus.MemWrite | (bus.Branch & ~bus.Jump));

  // Load in EX whose destination feeds the ID instruction; $zero never stalls
  assign hazard = bus.ex_valid & bus.ex_mem_read & (bus.ex_rt != '0)
                & ((uses_rs & (bus.id_rs == bus.ex_rt)) | (uses_rt & (bus.id_rt == bus.ex_rt)));

  // A flush squashes the dependent instruction anyway, so there is nothing to wait for
  assign stall_c   = hazard & ~bus.flush & ~rst;
  assign bus.stall = stall_c;
  assign bubble    = bus.flush | hazard;

  assign imm_ext = bus.ExtendSel ? {{(DATA_W-IMM_W){bus.id_imm[IMM_W-1]}}, bus.id_imm}
                                 : {{(DATA_W-IMM_W){1'b0}}, bus.id_imm};

  // Control/valid: bubbles clear them, invalid ID slots gate them so undecoded X never leaks
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ex_valid      <= 1'b0;
      bus.ex_reg_dst    <= 1'b0;
      bus.ex_alu_src    <= 1'b0;
      bus.ex_mem_to_reg <= 1'b0;
      bus.ex_reg_write  <= 1'b0;
      bus.ex_mem_read   <= 1'b0;
      bus.ex_mem_write  <= 1'b0;
      bus.ex_branch     <= 1'b0;
      bus.ex_jump       <= 1'b0;
      bus.ex_alu_op     <= '0;
    end else if (bubble) begin
      bus.ex_valid      <= 1'b0;
      bus.ex_reg_dst    <= 1'b0;
      bus.ex_alu_src    <= 1'b0;
      bus.ex_mem_to_reg <= 1'b0;
      bus.ex_reg_write  <= 1'b0;
      bus.ex_mem_read   <= 1'b0;
      bus.ex_mem_write  <= 1'b0;
      bus.ex_branch     <= 1'b0;
      bus.ex_jump       <= 1'b0;
      bus.ex_alu_op     <= '0;
    end else if (bus.id_valid) begin
      bus.ex_valid      <= 1'b1;
      bus.ex_reg_dst    <= bus.RegDst;
      bus.ex_alu_src    <= bus.ALUSrc;
      bus.ex_mem_to_reg <= bus.MemtoReg;
      bus.ex_reg_write  <= bus.RegWrite;
      bus.ex_mem_read   <= bus.MemRead;
      bus.ex_mem_write  <= bus.MemWrite;
      bus.ex_branch     <= bus.Branch;
      bus.ex_jump       <= bus.Jump;
      bus.ex_alu_op     <= bus.ALUOp;
    end else begin
      bus.ex_valid      <= 1'b0;
      bus.ex_reg_dst    <= 1'b0;
      bus.ex_alu_src    <= 1'b0;
      bus.ex_mem_to_reg <= 1'b0;
      bus.ex_reg_write  <= 1'b0;
      bus.ex_mem_read   <= 1'b0;
      bus.ex_mem_write  <= 1'b0;
      bus.ex_branch     <= 1'b0;
      bus.ex_jump       <= 1'b0;
      bus.ex_alu_op     <= OP_W'(0);
    end
  end

  // Data fields: held across bubbles, copied on every load
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ex_rs_data   <= '0;
      bus.ex_rt_data   <= '0;
      bus.ex_imm_ext   <= '0;
      bus.ex_pc4       <= '0;
      bus.ex_rs        <= '0;
      bus.ex_rt        <= '0;
      bus.ex_write_reg <= '0;
      bus.ex_funct     <= '0;
    end else if (!bubble) begin
      bus.ex_rs_data   <= bus.id_rs_data;
      bus.ex_rt_data   <= bus.id_rt_data;
      bus.ex_imm_ext   <= imm_ext;
      bus.ex_pc4       <= bus.id_pc4;
      bus.ex_rs        <= bus.id_rs;
      bus.ex_rt        <= bus.id_rt;
      bus.ex_write_reg <= bus.RegDst ? bus.id_rd : bus.id_rt;
      bus.ex_funct     <= bus.id_funct;
    end
  end

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.stall_cnt <= '0;
      bus.flush_cnt <= '0;
    end else begin
      if (stall_c && (bus.stall_cnt != CNT_MAX)) bus.stall_cnt <= bus.stall_cnt + CNT_W'(1);
      if (bus.flush && (bus.flush_cnt != CNT_MAX)) bus.flush_cnt <= bus.flush_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage with a scoreboard of expected EX contents.
// A second instance with 2-bit counters shares all inputs to exercise saturation.
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage_if #(.DATA_W(32), .CNT_W(16)) mif ();
  id_ex_stage_if #(.DATA_W(32), .CNT_W(2))  sif ();

  id_ex_stage #(.DATA_W(32), .CNT_W(16)) dut     (.clk(clk), .rst(rst), .bus(mif));
  id_ex_stage #(.DATA_W(32), .CNT_W(2))  sat_dut (.clk(clk), .rst(rst), .bus(sif));

  assign sif.id_valid   = mif.id_valid;
  assign sif.RegDst     = mif.RegDst;
  assign sif.ALUSrc     = mif.ALUSrc;
  assign sif.MemtoReg   = mif.MemtoReg;
  assign sif.RegWrite   = mif.RegWrite;
  assign sif.MemRead    = mif.MemRead;
  assign sif.MemWrite   = mif.MemWrite;
  assign sif.Branch     = mif.Branch;
  assign sif.Jump       = mif.Jump;
  assign sif.ExtendSel  = mif.ExtendSel;
  assign sif.ALUOp      = mif.ALUOp;
  assign sif.id_rs_data = mif.id_rs_data;
  assign sif.id_rt_data = mif.id_rt_data;
  assign sif.id_pc4     = mif.id_pc4;
  assign sif.id_rs      = mif.id_rs;
  assign sif.id_rt      = mif.id_rt;
  assign sif.id_rd      = mif.id_rd;
  assign sif.id_imm     = mif.id_imm;
  assign sif.id_funct   = mif.id_funct;
  assign sif.flush      = mif.flush;

  typedef struct packed {
    logic        valid;
    logic [9:0]  ctrl;
    logic        chk_data;
    logic [4:0]  wreg;
    logic [31:0] imm;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] pc4;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [5:0]  funct;
    logic [15:0] scnt;
    logic [15:0] fcnt;
    logic [1:0]  scnt2;
    logic [1:0]  fcnt2;
  } exp_t;

  exp_t sbq[$];

  // Reference view of the EX register, derived only from driven stimulus
  logic        m_valid = 1'b0;
  logic        m_mem_read = 1'b0;
  logic [4:0]  m_rt = 5'd0;
  logic [15:0] m_scnt = 16'd0;
  logic [15:0] m_fcnt = 16'd0;
  logic [1:0]  m_scnt2 = 2'd0;
  logic [1:0]  m_fcnt2 = 2'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic base(input logic v);
    mif.id_valid = v;
    mif.RegDst = 1'b0; mif.ALUSrc = 1'b0; mif.MemtoReg = 1'b0; mif.RegWrite = 1'b0;
    mif.MemRead = 1'b0; mif.MemWrite = 1'b0; mif.Branch = 1'b0; mif.Jump = 1'b0;
    mif.ExtendSel = 1'b0; mif.ALUOp = 2'b00; mif.flush = 1'b0;
    mif.id_rs_data = $urandom; mif.id_rt_data = $urandom; mif.id_pc4 = $urandom;
    mif.id_imm = 16'($urandom); mif.id_funct = 6'($urandom);
    mif.id_rs = 5'd0; mif.id_rt = 5'd0; mif.id_rd = 5'd0;
  endtask

  task automatic set_r(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    base(1'b1);
    mif.RegDst = 1'b1; mif.RegWrite = 1'b1; mif.ALUOp = 2'b10;
    mif.id_rd = rd; mif.id_rs = rs; mif.id_rt = rt; mif.id_funct = 6'h20;
  endtask

  task automatic set_lw(input logic [4:0] rt, input logic [4:0] rs);
    base(1'b1);
    mif.ALUSrc = 1'b1; mif.MemtoReg = 1'b1; mif.RegWrite = 1'b1; mif.MemRead = 1'b1;
    mif.ExtendSel = 1'b1; mif.id_rt = rt; mif.id_rs = rs; mif.id_imm = 16'hFFFC;
  endtask

  task automatic set_sw(input logic [4:0] rt, input logic [4:0] rs);
    base(1'b1);
    mif.ALUSrc = 1'b1; mif.MemWrite = 1'b1; mif.ExtendSel = 1'b1;
    mif.id_rt = rt; mif.id_rs = rs; mif.id_imm = 16'h0010;
  endtask

  // Inputs are already driven (after a falling edge); check stall, predict, clock, compare
  task automatic step(input string tag);
    exp_t e;
    logic urs, urt, hz, st;
    #1;
    urs = mif.id_valid & ~mif.Jump;
    urt = mif.id_valid & (mif.RegDst | mif.MemWrite | (mif.Branch & ~mif.Jump));
    hz  = m_valid & m_mem_read & (m_rt != 5'd0)
        & ((urs & (mif.id_rs == m_rt)) | (urt & (mif.id_rt == m_rt)));
    st  = hz & ~mif.flush & ~rst;
    check({tag, ".stall"}, 32'(mif.stall), 32'(st));

    e = '0;
    if (rst) begin
      m_valid = 1'b0; m_mem_read = 1'b0; m_rt = 5'd0;
      m_scnt = 16'd0; m_fcnt = 16'd0; m_scnt2 = 2'd0; m_fcnt2 = 2'd0;
      e.chk_data = 1'b1;
    end else begin
      if (st && m_scnt != 16'hFFFF) m_scnt++;
      if (st && m_scnt2 != 2'd3) m_scnt2++;
      if (mif.flush && m_fcnt != 16'hFFFF) m_fcnt++;
      if (mif.flush && m_fcnt2 != 2'd3) m_fcnt2++;
      if (mif.flush | hz) begin
        m_valid = 1'b0; m_mem_read = 1'b0;
      end else begin
        e.valid = mif.id_valid;
        if (mif.id_valid)
          e.ctrl = {mif.RegDst, mif.ALUSrc, mif.MemtoReg, mif.RegWrite, mif.MemRead,
                    mif.MemWrite, mif.Branch, mif.Jump, mif.ALUOp};
        e.chk_data = mif.id_valid;
        e.wreg    = mif.RegDst ? mif.id_rd : mif.id_rt;
        e.imm     = mif.ExtendSel ? {{16{mif.id_imm[15]}}, mif.id_imm} : {16'h0000, mif.id_imm};
        e.rs_data = mif.id_rs_data;
        e.rt_data = mif.id_rt_data;
        e.pc4     = mif.id_pc4;
        e.rs      = mif.id_rs;
        e.rt      = mif.id_rt;
        e.funct   = mif.id_funct;
        m_valid = mif.id_valid;
        m_mem_read = mif.id_valid & mif.MemRead;
        m_rt = mif.id_rt;
      end
    end
    e.scnt = m_scnt; e.fcnt = m_fcnt; e.scnt2 = m_scnt2; e.fcnt2 = m_fcnt2;
    sbq.push_back(e);

    @(posedge clk); #1;
    e = sbq.pop_front();
    check({tag, ".ex_valid"}, 32'(mif.ex_valid), 32'(e.valid));
    check({tag, ".ctrl"}, 32'({mif.ex_reg_dst, mif.ex_alu_src, mif.ex_mem_to_reg, mif.ex_reg_write,
                              mif.ex_mem_read, mif.ex_mem_write, mif.ex_branch, mif.ex_jump,
                              mif.ex_alu_op}), 32'(e.ctrl));
    check({tag, ".stall_cnt"}, 32'(mif.stall_cnt), 32'(e.scnt));
    check({tag, ".flush_cnt"}, 32'(mif.flush_cnt), 32'(e.fcnt));
    check({tag, ".sat_stall_cnt"}, 32'(sif.stall_cnt), 32'(e.scnt2));
    check({tag, ".sat_flush_cnt"}, 32'(sif.flush_cnt), 32'(e.fcnt2));
    if (e.chk_data) begin
      check({tag, ".write_reg"}, 32'(mif.ex_write_reg), 32'(e.wreg));
      check({tag, ".imm_ext"}, mif.ex_imm_ext, e.imm);
      check({tag, ".rs_data"}, mif.ex_rs_data, e.rs_data);
      check({tag, ".rt_data"}, mif.ex_rt_data, e.rt_data);
      check({tag, ".pc4"}, mif.ex_pc4, e.pc4);
      check({tag, ".rs"}, 32'(mif.ex_rs), 32'(e.rs));
      check({tag, ".rt"}, 32'(mif.ex_rt), 32'(e.rt));
      check({tag, ".funct"}, 32'(mif.ex_funct), 32'(e.funct));
    end
    @(negedge clk);
  endtask

  task automatic all_ones();
    mif.id_valid = 1'b1;
    mif.RegDst = 1'b1; mif.ALUSrc = 1'b1; mif.MemtoReg = 1'b1; mif.RegWrite = 1'b1;
    mif.MemRead = 1'b1; mif.MemWrite = 1'b1; mif.Branch = 1'b1; mif.Jump = 1'b1;
    mif.ExtendSel = 1'b1; mif.ALUOp = 2'b11; mif.flush = 1'b1;
    mif.id_rs_data = '1; mif.id_rt_data = '1; mif.id_pc4 = '1;
    mif.id_rs = '1; mif.id_rt = '1; mif.id_rd = '1; mif.id_imm = '1; mif.id_funct = '1;
  endtask

  initial begin
    rst = 1'b1;
    all_ones();
    @(negedge clk);

    // Reset with every input high
    step("reset");
    rst = 1'b0;

    // R-type add, zero-extended immediate
    set_r(5'd3, 5'd1, 5'd2);
    mif.id_imm = 16'h8000; mif.ExtendSel = 1'b0;
    step("rtype");
    check("rtype.write_reg_direct", 32'(mif.ex_write_reg), 32'd3);
    check("rtype.imm_direct", mif.ex_imm_ext, 32'h0000_8000);

    // Load-use on rs: one stall cycle, then the add proceeds
    set_lw(5'd5, 5'd1);   step("lw5");
    set_r(5'd6, 5'd5, 5'd7); step("use_rs_stall");
    step("use_rs_go");

    // Load to $zero never stalls
    set_lw(5'd0, 5'd2);   step("lw0");
    set_r(5'd4, 5'd0, 5'd0); step("use_zero");

    // Store in EX (no MemRead) never stalls
    set_sw(5'd5, 5'd1);   step("sw");
    set_r(5'd4, 5'd5, 5'd1); step("after_sw");

    // Load-use coinciding with flush: counted as flush only
    set_lw(5'd8, 5'd1);   step("lw8");
    set_r(5'd9, 5'd8, 5'd1); mif.flush = 1'b1; step("hazard_flush");

    // Hazard through rt of a store, and jump ignoring rs
    set_lw(5'd9, 5'd1);   step("lw9");
    set_sw(5'd9, 5'd2);   step("use_rt_stall");
    step("use_rt_go");
    set_lw(5'd10, 5'd1);  step("lw10");
    base(1'b1); mif.Jump = 1'b1; mif.id_rs = 5'd10; step("jump_nostall");

    // Invalid ID slot with every control bit asserted
    base(1'b0);
    mif.RegDst = 1'b1; mif.ALUSrc = 1'b1; mif.MemtoReg = 1'b1; mif.RegWrite = 1'b1;
    mif.MemRead = 1'b1; mif.MemWrite = 1'b1; mif.Branch = 1'b1; mif.Jump = 1'b1;
    mif.ALUOp = 2'b11;
    step("invalid_slot");

    // Reset mid-hazard clears it
    set_lw(5'd5, 5'd1);   step("lw5_pre_rst");
    set_r(5'd6, 5'd5, 5'd7); rst = 1'b1; step("rst_mid_hazard");
    rst = 1'b0;
    step("post_rst_no_stall");

    // Drive the 2-bit instance into saturation
    for (int i = 0; i < 5; i++) begin
      set_lw(5'd4, 5'd1);   step("sat_lw");
      set_r(5'd2, 5'd4, 5'd3); step("sat_stall");
      step("sat_go");
    end
    check("sat_hold_max", 32'(sif.stall_cnt), 32'd3);
    check("wide_cnt_count", 32'(mif.stall_cnt), 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
